// File: rtl/aclk_lcd_frame_driver.sv
// Alarm-clock LCD frame driver: snapshots the selected multi-digit BCD value and streams it
// MSD-first as ASCII over valid/ready. A separate edge-triggered alarm runs beside it.
module aclk_lcd_frame_driver #(
  parameter int NUM_DIGITS   = 4,
  parameter int FRAME_GAP    = 16,
  parameter int ALARM_CYCLES = 1024,
  parameter int CNT_W        = 16
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic [4*NUM_DIGITS-1:0] alarm_time,
  input  logic [4*NUM_DIGITS-1:0] current_time,
  input  logic [4*NUM_DIGITS-1:0] key_buffer,
  input  logic                    show_alarm,
  input  logic                    show_new_time,
  input  logic                    alarm_en,
  input  logic                    alarm_off,
  input  logic                    lcd_ready,
  output logic                    lcd_valid,
  output logic [7:0]              lcd_data,
  output logic                    lcd_first,
  output logic                    sound_alarm
);

  localparam int IDX_W = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;

  localparam logic [1:0] ST_GAP  = 2'd0;
  localparam logic [1:0] ST_LOAD = 2'd1;
  localparam logic [1:0] ST_SEND = 2'd2;

  logic [1:0]              r_state;
  logic [CNT_W-1:0]        r_gapCnt;
  logic                    r_fastStart;
  logic [IDX_W-1:0]        r_idx;
  logic [4*NUM_DIGITS-1:0] r_frame;
  logic                    r_valid;
  logic [7:0]              r_data;
  logic                    r_first;

  logic                    r_match;
  logic                    r_matchQ;
  logic                    r_sound;
  logic [CNT_W-1:0]        r_alarmCnt;

  logic [4*NUM_DIGITS-1:0] w_src;
  logic [IDX_W-1:0]        w_nextIdx;
  logic [3:0]              w_nextDigit;
  logic [3:0]              w_msDigit;
  logic                    w_trigger;
  logic                    w_clear;

  function automatic logic [7:0] decodeDigit(input logic [3:0] d);
    return (d <= 4'd9) ? {4'h3, d} : 8'h3A;
  endfunction

  always_comb begin
    w_src = current_time;
    if (show_new_time)
      w_src = key_buffer;
    else if (show_alarm)
      w_src = alarm_time;
  end

  assign w_nextIdx   = r_idx - 1'b1;
  assign w_nextDigit = r_frame[w_nextIdx*4 +: 4];
  assign w_msDigit   = w_src[4*(NUM_DIGITS-1) +: 4];

  // r_fastStart skips the gap once after reset so the first frame loads immediately.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state     <= ST_GAP;
      r_gapCnt    <= '0;
      r_fastStart <= 1'b1;
      r_idx       <= '0;
      r_frame     <= '0;
      r_valid     <= 1'b0;
      r_data      <= 8'h00;
      r_first     <= 1'b0;
    end else begin
      case (r_state)
        ST_GAP: begin
          if (r_fastStart || (r_gapCnt == CNT_W'(FRAME_GAP - 1))) begin
            r_state     <= ST_LOAD;
            r_gapCnt    <= '0;
            r_fastStart <= 1'b0;
          end else begin
            r_gapCnt <= r_gapCnt + 1'b1;
          end
        end
        ST_LOAD: begin
          r_frame <= w_src;
          r_idx   <= IDX_W'(NUM_DIGITS - 1);
          r_valid <= 1'b1;
          r_data  <= decodeDigit(w_msDigit);
          r_first <= 1'b1;
          r_state <= ST_SEND;
        end
        ST_SEND: begin
          if (lcd_ready) begin
            r_first <= 1'b0;
            if (r_idx == '0) begin
              r_valid <= 1'b0;
              r_state <= ST_GAP;
            end else begin
              r_idx  <= w_nextIdx;
              r_data <= decodeDigit(w_nextDigit);
            end
          end
        end
        default: begin
          r_state <= ST_GAP;
          r_valid <= 1'b0;
          r_first <= 1'b0;
        end
      endcase
    end
  end

  assign w_trigger = r_match && !r_matchQ;
  assign w_clear   = (r_sound && (r_alarmCnt == CNT_W'(ALARM_CYCLES - 1))) || alarm_off || !alarm_en;

  // Clearing wins over a simultaneous trigger; a persisting match never retriggers.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_match    <= 1'b0;
      r_matchQ   <= 1'b0;
      r_sound    <= 1'b0;
      r_alarmCnt <= '0;
    end else begin
      r_match  <= alarm_en && (current_time == alarm_time);
      r_matchQ <= r_match;
      if (w_clear) begin
        r_sound    <= 1'b0;
        r_alarmCnt <= '0;
      end else if (w_trigger) begin
        r_sound    <= 1'b1;
        r_alarmCnt <= '0;
      end else if (r_sound) begin
        r_alarmCnt <= r_alarmCnt + 1'b1;
      end
    end
  end

  assign lcd_valid   = r_valid;
  assign lcd_data    = r_data;
  assign lcd_first   = r_first;
  assign sound_alarm = r_sound;

endmodule

// File: tb/tb_aclk_lcd_frame_driver.sv
// Bench for aclk_lcd_frame_driver: expected characters are queued as frames are set up
// and popped by a monitor on every handshake; alarm and reset behaviour are checked directly.
module tb_aclk_lcd_frame_driver;

  localparam int ND = 4;
  localparam int FG = 16;
  localparam int AC = 20;

  logic        clk = 1'b0;
  logic        reset;
  logic [15:0] alarm_time, current_time, key_buffer;
  logic        show_alarm, show_new_time, alarm_en, alarm_off, lcd_ready;
  logic        lcd_valid, lcd_first, sound_alarm;
  logic [7:0]  lcd_data;

  typedef struct {
    logic [7:0] ch;
    logic       first;
  } exp_t;

  exp_t expQ[$];
  int   firstCycles[$];
  int   total = 0;
  int   bad = 0;
  int   xferCount = 0;
  int   cycle = 0;
  int   releaseCycle;

  aclk_lcd_frame_driver #(
    .NUM_DIGITS(ND), .FRAME_GAP(FG), .ALARM_CYCLES(AC), .CNT_W(16)
  ) dut (
    .clk(clk), .reset(reset),
    .alarm_time(alarm_time), .current_time(current_time), .key_buffer(key_buffer),
    .show_alarm(show_alarm), .show_new_time(show_new_time),
    .alarm_en(alarm_en), .alarm_off(alarm_off), .lcd_ready(lcd_ready),
    .lcd_valid(lcd_valid), .lcd_data(lcd_data), .lcd_first(lcd_first),
    .sound_alarm(sound_alarm)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cycle = cycle + 1;

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    total++;
    if (observed !== expected) begin
      bad++;
      $display("[TB] FAIL %s: got %0h expected %0h", tag, observed, expected);
    end
  endtask

  // Transfer monitor: a handshake seen at the negedge completes on the following posedge.
  always @(negedge clk) begin
    exp_t e;
    if (!reset && lcd_valid && lcd_ready) begin
      if (expQ.size() == 0) begin
        checkOutput("unexpected char", {24'h0, lcd_data}, 32'hFFFF_FFFF);
      end else begin
        e = expQ.pop_front();
        checkOutput("char", {24'h0, lcd_data}, {24'h0, e.ch});
        checkOutput("first flag", {31'h0, lcd_first}, {31'h0, e.first});
      end
      if (lcd_first) firstCycles.push_back(cycle);
      xferCount++;
    end
  end

  task automatic pushFrame(input logic [15:0] digits);
    exp_t e;
    logic [3:0] d;
    for (int i = ND - 1; i >= 0; i--) begin
      d       = digits[i*4 +: 4];
      e.ch    = (d < 4'd10) ? (8'h30 + {4'h0, d}) : 8'h3A;
      e.first = (i == ND - 1);
      expQ.push_back(e);
    end
  endtask

  task automatic applyStimulus(input logic newT, input logic alm, input logic [15:0] cur,
                               input logic [15:0] almT, input logic [15:0] key);
    show_new_time = newT;
    show_alarm    = alm;
    current_time  = cur;
    alarm_time    = almT;
    key_buffer    = key;
  endtask

  task automatic waitXfers(input int target);
    int n = 0;
    while (xferCount < target && n < 300) begin
      @(posedge clk); #1;
      n++;
    end
    checkOutput("transfer count", xferCount, target);
  endtask

  task automatic stepCycles(input int n);
    repeat (n) begin
      @(posedge clk); #1;
    end
  endtask

  initial begin
    reset = 1'b1;
    lcd_ready = 1'b1;
    alarm_en = 1'b0;
    alarm_off = 1'b0;
    applyStimulus(1'b0, 1'b0, 16'h1234, 16'h0000, 16'h0000);
    stepCycles(3);
    checkOutput("reset valid", {31'h0, lcd_valid}, 0);
    checkOutput("reset data", {24'h0, lcd_data}, 0);
    checkOutput("reset first", {31'h0, lcd_first}, 0);
    checkOutput("reset sound", {31'h0, sound_alarm}, 0);

    // Two back-to-back frames of current_time
    pushFrame(16'h1234);
    pushFrame(16'h1234);
    releaseCycle = cycle;
    reset = 1'b0;
    waitXfers(8);
    checkOutput("first frame start", firstCycles[0], releaseCycle + 2);
    checkOutput("frame period", firstCycles[1] - firstCycles[0], 1 + ND + FG);

    // Backpressure on the second character
    pushFrame(16'h1234);
    waitXfers(9);
    lcd_ready = 1'b0;
    checkOutput("stall valid", {31'h0, lcd_valid}, 1);
    checkOutput("stall data", {24'h0, lcd_data}, 32'h32);
    for (int i = 0; i < 5; i++) begin
      stepCycles(1);
      checkOutput("stall valid held", {31'h0, lcd_valid}, 1);
      checkOutput("stall data held", {24'h0, lcd_data}, 32'h32);
    end
    lcd_ready = 1'b1;
    waitXfers(12);

    // Snapshot: select flips and sources change mid-frame
    applyStimulus(1'b1, 1'b0, 16'h1234, 16'h0000, 16'h0959);
    pushFrame(16'h0959);
    pushFrame(16'h5678);
    waitXfers(13);
    applyStimulus(1'b0, 1'b0, 16'h5678, 16'h0000, 16'h1111);
    waitXfers(20);
    checkOutput("period after stall", firstCycles[4] - firstCycles[3], 1 + ND + FG);

    // Error digit through alarm_time selection
    applyStimulus(1'b0, 1'b1, 16'h5678, 16'h12F4, 16'h1111);
    pushFrame(16'h12F4);
    waitXfers(24);
    checkOutput("queue drained", expQ.size(), 0);

    // Alarm: trigger, timeout, no retrigger while match persists
    lcd_ready = 1'b0;
    alarm_en  = 1'b1;
    applyStimulus(1'b0, 1'b0, 16'h0659, 16'h0700, 16'h1111);
    stepCycles(3);
    checkOutput("alarm idle", {31'h0, sound_alarm}, 0);
    current_time = 16'h0700;
    stepCycles(1);
    checkOutput("alarm latency", {31'h0, sound_alarm}, 0);
    stepCycles(1);
    checkOutput("alarm on", {31'h0, sound_alarm}, 1);
    stepCycles(AC - 1);
    checkOutput("alarm held", {31'h0, sound_alarm}, 1);
    stepCycles(1);
    checkOutput("alarm timeout", {31'h0, sound_alarm}, 0);
    stepCycles(5);
    checkOutput("no retrigger", {31'h0, sound_alarm}, 0);

    // Retrigger after the match falls, then stop with alarm_off
    current_time = 16'h0659;
    stepCycles(3);
    current_time = 16'h0700;
    stepCycles(2);
    checkOutput("retrigger", {31'h0, sound_alarm}, 1);
    alarm_off = 1'b1;
    stepCycles(1);
    checkOutput("alarm_off stop", {31'h0, sound_alarm}, 0);
    alarm_off = 1'b0;
    stepCycles(4);
    checkOutput("stopped stays low", {31'h0, sound_alarm}, 0);

    // Async reset while sounding and stalled in SEND
    current_time = 16'h0659;
    stepCycles(3);
    current_time = 16'h0700;
    stepCycles(2);
    checkOutput("pre-reset sound", {31'h0, sound_alarm}, 1);
    checkOutput("pre-reset valid", {31'h0, lcd_valid}, 1);
    #2 reset = 1'b1;
    #1;
    checkOutput("async valid", {31'h0, lcd_valid}, 0);
    checkOutput("async data", {24'h0, lcd_data}, 0);
    checkOutput("async first", {31'h0, lcd_first}, 0);
    checkOutput("async sound", {31'h0, sound_alarm}, 0);
    stepCycles(2);
    expQ.delete();
    alarm_en  = 1'b0;
    lcd_ready = 1'b1;
    applyStimulus(1'b0, 1'b0, 16'h1234, 16'h0700, 16'h1111);
    pushFrame(16'h1234);
    releaseCycle = cycle;
    reset = 1'b0;
    waitXfers(28);
    checkOutput("restart timing", firstCycles[$], releaseCycle + 2);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog");
  end

endmodule

// File: doc/aclk_lcd_frame_driver.md
Name: aclk_lcd_frame_driver

Overview:
Parametrised successor to the single-digit alarm-clock LCD decoder. Handles NUM_DIGITS BCD digits per source and selects key entry, alarm time or current time. Each selected frame is snapshotted and streamed to the LCD controller as ASCII characters over a valid/ready handshake, most significant digit first. Alarm detection is registered and edge-triggered, with a timeout and an explicit stop input; it sits between the alarm-clock datapath (counter/alarm/key registers) and the LCD interface.

Parameters:
NUM_DIGITS, 4, BCD digits per time value (1..8)
FRAME_GAP, 16, idle cycles between end of one frame and next snapshot (>=1)
ALARM_CYCLES, 1024, max cycles sound_alarm stays high once triggered (>=1)
CNT_W, 16, width of gap/alarm counters; must hold max(FRAME_GAP, ALARM_CYCLES)

Ports:
clk  input  1  system clock, all state on rising edge
reset  input  1  asynchronous, active-high reset
alarm_time  input  4*NUM_DIGITS  alarm BCD digits, digit 0 = LSBs
current_time  input  4*NUM_DIGITS  current time BCD digits
key_buffer  input  4*NUM_DIGITS  new-time digits from keypad
show_alarm  input  1  select alarm_time for display
show_new_time  input  1  select key_buffer for display (priority over show_alarm)
alarm_en  input  1  alarm armed
alarm_off  input  1  stop sounding alarm (level)
lcd_ready  input  1  LCD controller accepts character
lcd_valid  output  1  lcd_data valid
lcd_data  output  8  ASCII character
lcd_first  output  1  high with first character of a frame (cursor home)
sound_alarm  output  1  alarm buzzer drive

Behaviour:
- Reset values: lcd_valid=0, lcd_data=8'h00, lcd_first=0, sound_alarm=0, FSM=GAP with gap counter=0 (first LOAD occurs 1 cycle after reset release), digit index=0, match history=0.
- Source mux: show_new_time -> key_buffer; else show_alarm -> alarm_time; else current_time.
- Decode per digit: 0..9 -> 8'h30..8'h39; 10..15 -> 8'h3A (error).
- FSM states: GAP, LOAD, SEND.
  - GAP: counter increments; when it reaches FRAME_GAP-1 (or immediately after reset as above) -> LOAD, counter cleared.
  - LOAD (1 cycle): capture whole mux output into frame register; index=NUM_DIGITS-1 -> SEND. Source/select changes after LOAD do not affect the current frame.
  - SEND: lcd_valid=1, lcd_data=decode(frame[index]), lcd_first=1 iff index==NUM_DIGITS-1. Transfer occurs on a rising edge with lcd_valid&&lcd_ready. On transfer: if index==0 -> GAP (lcd_valid=0 next cycle), else index-1. lcd_data/lcd_first stable while lcd_valid&&!lcd_ready. lcd_valid never drops without a transfer.
  - lcd_data holds the last value when lcd_valid=0.
- Back-to-back: with lcd_ready tied high, a frame takes exactly NUM_DIGITS SEND cycles; frame period = 1 + NUM_DIGITS + FRAME_GAP cycles.
- Alarm: match = alarm_en && (current_time == alarm_time) over all digits, registered (match_q). Trigger = match && !match_q (rising edge), taking effect next cycle.
  - sound_alarm set on trigger; alarm counter cleared.
  - While sound_alarm=1, alarm counter increments; clear when counter reaches ALARM_CYCLES-1, or alarm_off=1, or alarm_en=0.
  - Clear has priority over trigger in the same cycle.
  - A persisting match does not retrigger; retrigger requires match to fall, then rise again.
- Reset mid-frame: lcd_valid drops immediately (async), frame aborted; a fresh frame starts after release.

Test Plan:
- Reset, NUM_DIGITS=4, current_time=16'h1234, lcd_ready=1 -> chars 31,32,33,34; lcd_first only on 31; next frame starts 1+4+16 cycles later.
- Backpressure: lcd_ready low for 5 cycles during 2nd char -> lcd_data=8'h32 and lcd_valid held stable; no char lost or duplicated.
- Selection/snapshot: show_new_time=1, key_buffer=16'h0959, toggled to 0 mid-frame -> full frame 30,39,35,39; next frame shows current_time.
- Error digit: alarm_time=16'h12F4, show_alarm=1 -> 31,32,3A,34.
- Alarm: alarm_en=1, alarm_time=16'h0700, current_time steps 16'h0659->16'h0700 -> sound_alarm high one cycle after match registers, low after exactly ALARM_CYCLES cycles; match still present -> no retrigger.
- Stop and async reset: alarm sounding, alarm_off pulse -> sound_alarm low next edge; assert reset during SEND -> all outputs at reset values without a clock edge.
